// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state type and geometry helpers for the read-only set-associative cache.
// Revision 1.0
`default_nettype none

package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2
  } cache_state_t;

  function automatic int tag_width(input int addr_width, input int set_bits);
    return addr_width - set_bits;
  endfunction

  function automatic int num_sets(input int set_bits);
    return 1 << set_bits;
  endfunction

  // A single-way cache still needs a 1-bit way index to keep vectors legal.
  function automatic int way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: picks the lowest invalid way, else the round-robin way (and flags the pointer use).
// Revision 1.0
`default_nettype none

module cache_victim_sel #(
  parameter int WAYS  = 2,
  parameter int WAY_W = 1
) (
  input  logic [WAYS-1:0]  valid_vec,
  input  logic [WAY_W-1:0] rr_ptr,
  output logic [WAY_W-1:0] victim,
  output logic             use_rr
);

  // Scanning downward leaves the lowest-index invalid way as the final pick.
  always_comb begin
    victim = rr_ptr;
    use_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_vec[w]) begin
        victim = WAY_W'(w);
        use_rr = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_set_assoc_ro.sv
// cache_set_assoc_ro: read-only WAYS-way set-associative cache with zero-cycle hits and a single outstanding miss.
// Revision 1.0
`default_nettype none

module cache_set_assoc_ro
  import cache_pkg::*;
#(
  parameter int DWIDTH     = 20,
  parameter int ADDR_WIDTH = 16,
  parameter int SET_BITS   = 4,
  parameter int WAYS       = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  addr_in_valid,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  addr_in_ready,
  output logic [DWIDTH-1:0]     data_out,
  output logic                  addr_out_valid,
  output logic [ADDR_WIDTH-1:0] addr_out,
  input  logic                  addr_out_ready,
  input  logic                  data_in_valid,
  input  logic [DWIDTH-1:0]     data_in,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int SETS  = num_sets(SET_BITS);
  localparam int TAG_W = tag_width(ADDR_WIDTH, SET_BITS);
  localparam int WAY_W = way_width(WAYS);

  cache_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  flush_pend;
  logic [WAYS-1:0]       valid_q  [SETS];
  logic [WAY_W-1:0]      rr_ptr   [SETS];
  logic [TAG_W-1:0]      tag_mem  [SETS][WAYS];
  logic [DWIDTH-1:0]     data_mem [SETS][WAYS];

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_W-1:0]    tag;
  logic [SET_BITS-1:0] fill_set;
  logic [TAG_W-1:0]    fill_tag;

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [DWIDTH-1:0] hit_data;
  logic [WAY_W-1:0]  victim;
  logic              use_rr;
  logic [WAY_W-1:0]  rr_next;

  logic flush_now;
  logic do_hit;
  logic do_miss;
  logic do_flush;
  logic do_fill;

  assign set_idx  = addr_in[SET_BITS-1:0];
  assign tag      = addr_in[ADDR_WIDTH-1:SET_BITS];
  assign fill_set = req_addr[SET_BITS-1:0];
  assign fill_tag = req_addr[ADDR_WIDTH-1:SET_BITS];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_mem[set_idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_data = data_mem[set_idx][hit_way];

  cache_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_victim_sel (
    .valid_vec (valid_q[fill_set]),
    .rr_ptr    (rr_ptr[fill_set]),
    .victim    (victim),
    .use_rr    (use_rr)
  );

  assign rr_next = (rr_ptr[fill_set] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[fill_set] + 1'b1;

  // A pending flush behaves exactly like a fresh one once back in S_IDLE, so it also blocks that cycle's request.
  assign flush_now = flush | flush_pend;
  assign do_flush  = (state == S_IDLE) && flush_now;
  assign do_hit    = (state == S_IDLE) && !flush_now && addr_in_valid && hit;
  assign do_miss   = (state == S_IDLE) && !flush_now && addr_in_valid && !hit;
  assign do_fill   = (state == S_FILL) && data_in_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (do_miss) state_nxt = S_REQ;
      S_REQ:  if (addr_out_ready) state_nxt = S_FILL;
      S_FILL: if (data_in_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    addr_in_ready  = 1'b0;
    data_out       = '0;
    addr_out_valid = 1'b0;
    addr_out       = '0;
    case (state)
      S_IDLE: begin
        if (do_hit) begin
          addr_in_ready = 1'b1;
          data_out      = hit_data;
        end
      end
      S_REQ: begin
        addr_out_valid = 1'b1;
        addr_out       = req_addr;
      end
      S_FILL: begin
        if (data_in_valid) begin
          addr_in_ready = 1'b1;
          data_out      = data_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr   <= '0;
      flush_pend <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_ptr[s]  <= '0;
      end
    end else begin
      if (do_miss) req_addr <= addr_in;

      if (do_flush) begin
        flush_pend <= 1'b0;
      end else if (flush && (state != S_IDLE)) begin
        flush_pend <= 1'b1;
      end

      if (do_flush) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          rr_ptr[s]  <= '0;
        end
      end else if (do_fill) begin
        valid_q[fill_set][victim] <= 1'b1;
        if (use_rr) rr_ptr[fill_set] <= rr_next;
      end

      if (do_hit && (hit_count != '1)) hit_count <= hit_count + 1'b1;
      if (do_fill && (miss_count != '1)) miss_count <= miss_count + 1'b1;
    end
  end

  // Tag/data storage carries no reset; validity alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (do_fill) begin
      tag_mem[fill_set][victim]  <= fill_tag;
      data_mem[fill_set][victim] <= data_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_set_assoc_ro.sv
// tb_cache_set_assoc_ro: directed stimulus with a line-level reference model checked every cycle.
// Revision 1.0
`default_nettype none

module tb_cache_set_assoc_ro;

  localparam int DW   = 20;
  localparam int AW   = 16;
  localparam int SB   = 4;
  localparam int WAYS = 2;
  localparam int CW   = 4;
  localparam int SETS = 16;
  localparam int TW   = AW - SB;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          addr_in_valid = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic          addr_in_ready;
  logic [DW-1:0] data_out;
  logic          addr_out_valid;
  logic [AW-1:0] addr_out;
  logic          addr_out_ready = 1'b0;
  logic          data_in_valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          flush = 1'b0;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  always #5 clk = ~clk;

  cache_set_assoc_ro #(
    .DWIDTH     (DW),
    .ADDR_WIDTH (AW),
    .SET_BITS   (SB),
    .WAYS       (WAYS),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .addr_in_valid  (addr_in_valid),
    .addr_in        (addr_in),
    .addr_in_ready  (addr_in_ready),
    .data_out       (data_out),
    .addr_out_valid (addr_out_valid),
    .addr_out       (addr_out),
    .addr_out_ready (addr_out_ready),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .flush          (flush),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: lines per set, a round-robin pointer per set, and a coarse phase (0 idle, 1 request, 2 fill).
  bit            m_v [SETS][WAYS];
  logic [TW-1:0] m_t [SETS][WAYS];
  logic [DW-1:0] m_d [SETS][WAYS];
  int            m_rr [SETS];
  int            m_phase;
  logic [AW-1:0] m_addr;
  bit            m_pend;
  int            m_hits;
  int            m_miss;

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_v[s][w] = 1'b0;
    end
    m_phase = 0;
    m_addr  = '0;
    m_pend  = 1'b0;
    m_hits  = 0;
    m_miss  = 0;
  endtask

  task automatic m_lookup(input logic [AW-1:0] a, output bit h, output logic [DW-1:0] d);
    int s;
    s = int'(a[SB-1:0]);
    h = 1'b0;
    d = '0;
    for (int w = 0; w < WAYS; w++)
      if (m_v[s][w] && m_t[s][w] == a[AW-1:SB]) begin
        h = 1'b1;
        d = m_d[s][w];
      end
  endtask

  task automatic m_expect(output bit rdy, output logic [DW-1:0] d, output bit aov, output logic [AW-1:0] ao);
    bit h;
    logic [DW-1:0] hd;
    rdy = 1'b0; d = '0; aov = 1'b0; ao = '0;
    if (m_phase == 0) begin
      m_lookup(addr_in, h, hd);
      if (addr_in_valid && h && !(flush || m_pend)) begin
        rdy = 1'b1;
        d   = hd;
      end
    end else if (m_phase == 1) begin
      aov = 1'b1;
      ao  = m_addr;
    end else if (data_in_valid) begin
      rdy = 1'b1;
      d   = data_in;
    end
  endtask

  task automatic m_step();
    bit h;
    logic [DW-1:0] hd;
    int s, v;
    case (m_phase)
      0: begin
        m_lookup(addr_in, h, hd);
        if (flush || m_pend) begin
          for (int i = 0; i < SETS; i++) begin
            m_rr[i] = 0;
            for (int w = 0; w < WAYS; w++) m_v[i][w] = 1'b0;
          end
          m_pend = 1'b0;
        end else if (addr_in_valid && h) begin
          if (m_hits < CMAX) m_hits++;
        end else if (addr_in_valid) begin
          m_addr  = addr_in;
          m_phase = 1;
        end
      end
      1: begin
        if (flush) m_pend = 1'b1;
        if (addr_out_ready) m_phase = 2;
      end
      default: begin
        if (flush) m_pend = 1'b1;
        if (data_in_valid) begin
          s = int'(m_addr[SB-1:0]);
          v = -1;
          for (int w = 0; w < WAYS; w++) if (!m_v[s][w] && v < 0) v = w;
          if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % WAYS;
          end
          m_v[s][v] = 1'b1;
          m_t[s][v] = m_addr[AW-1:SB];
          m_d[s][v] = data_in;
          if (m_miss < CMAX) m_miss++;
          m_phase = 0;
        end
      end
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else m_step();
    end
  end

  initial begin
    bit e_rdy, e_aov;
    logic [DW-1:0] e_d;
    logic [AW-1:0] e_ao;
    forever begin
      @(negedge clk);
      m_expect(e_rdy, e_d, e_aov, e_ao);
      chk("addr_in_ready", 64'(addr_in_ready), 64'(e_rdy));
      chk("data_out", 64'(data_out), 64'(e_d));
      chk("addr_out_valid", 64'(addr_out_valid), 64'(e_aov));
      chk("addr_out", 64'(addr_out), 64'(e_ao));
      chk("hit_count", 64'(hit_count), 64'(m_hits));
      chk("miss_count", 64'(miss_count), 64'(m_miss));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one read and plays the downstream memory; n is the cycle index (0 = request cycle) on which ready rose.
  task automatic read(input logic [AW-1:0] a, input logic [DW-1:0] fd, input int ar_wait,
                      input int dv_wait, input bit flush_in_fill,
                      output logic [DW-1:0] got, output int n);
    int  aov_seen = 0;
    int  fc = 0;
    bit  hs = 1'b0;
    bit  done = 1'b0;
    addr_in = a; addr_in_valid = 1'b1;
    addr_out_ready = (ar_wait == 0);
    data_in_valid = 1'b0; data_in = '0; flush = 1'b0;
    got = '0; n = -1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (addr_in_ready) begin
        got = data_out; n = c; done = 1'b1;
      end else begin
        if (addr_out_valid) begin
          chk("addr_out_hold", 64'(addr_out), 64'(a));
          aov_seen++;
          if (addr_out_ready) hs = 1'b1;
        end
        tick();
        flush = 1'b0; data_in_valid = 1'b0;
        if (!hs) addr_out_ready = (aov_seen >= ar_wait);
        else begin
          addr_out_ready = 1'b0;
          if (flush_in_fill && fc == 0) flush = 1'b1;
          if (fc == dv_wait) begin data_in_valid = 1'b1; data_in = fd; end
          fc++;
        end
      end
    end
    if (!done) chk("read_timeout", 64'(0), 64'(1));
    tick();
    addr_in_valid = 1'b0; addr_in = '0; addr_out_ready = 1'b0;
    data_in_valid = 1'b0; data_in = '0; flush = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] got;
    int n;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(addr_in_ready), 64'(0));
    chk("rst_aov", 64'(addr_out_valid), 64'(0));
    chk("rst_hits", 64'(hit_count), 64'(0));
    tick();
    rst = 1'b1;
    tick();

    read(16'h0123, 20'hABCDE, 0, 0, 1'b0, got, n);
    chk("cold_data", 64'(got), 64'h0ABCDE);
    chk("cold_lat", 64'(n), 64'(2));
    @(negedge clk); chk("cold_misses", 64'(miss_count), 64'(1));
    tick();

    read(16'h0123, 20'h00000, 0, 0, 1'b0, got, n);
    chk("hit_data", 64'(got), 64'h0ABCDE);
    chk("hit_lat", 64'(n), 64'(0));
    @(negedge clk); chk("hit_count1", 64'(hit_count), 64'(1));
    tick();

    read(16'h0010, 20'h00010, 0, 0, 1'b0, got, n); chk("conf_a_lat", 64'(n), 64'(2));
    read(16'h0110, 20'h00110, 0, 0, 1'b0, got, n); chk("conf_b_lat", 64'(n), 64'(2));
    read(16'h0210, 20'h00210, 0, 0, 1'b0, got, n); chk("conf_c_lat", 64'(n), 64'(2));
    read(16'h0110, 20'h00000, 0, 0, 1'b0, got, n);
    chk("conf_b_hit", 64'(n), 64'(0));
    chk("conf_b_data", 64'(got), 64'h00110);
    read(16'h0010, 20'h0A010, 0, 0, 1'b0, got, n);
    chk("conf_a_evicted", 64'(n), 64'(2));
    chk("conf_a_data", 64'(got), 64'h0A010);

    read(16'h0456, 20'h45678, 5, 0, 1'b0, got, n);
    chk("bp_lat", 64'(n), 64'(7));
    chk("bp_data", 64'(got), 64'h45678);

    read(16'h0300, 20'h30000, 0, 1, 1'b1, got, n);
    chk("ff_lat", 64'(n), 64'(3));
    chk("ff_data", 64'(got), 64'h30000);
    read(16'h0456, 20'h45679, 0, 0, 1'b0, got, n);
    chk("ff_old_miss", 64'(n), 64'(3));
    chk("ff_old_data", 64'(got), 64'h45679);
    read(16'h0300, 20'h30001, 0, 0, 1'b0, got, n);
    chk("ff_filled_miss", 64'(n), 64'(2));

    for (int i = 0; i < 20; i++) read(16'h0300, 20'h00000, 0, 0, 1'b0, got, n);
    @(negedge clk);
    chk("hit_sat", 64'(hit_count), 64'(15));
    chk("miss_total", 64'(miss_count), 64'(9));
    tick();

    addr_in = 16'h0555; addr_in_valid = 1'b1; addr_out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_fill_ready", 64'(addr_in_ready), 64'(0));
    chk("rst_fill_aov", 64'(addr_out_valid), 64'(0));
    chk("rst_fill_hits", 64'(hit_count), 64'(0));
    chk("rst_fill_miss", 64'(miss_count), 64'(0));
    addr_in_valid = 1'b0; addr_in = '0; addr_out_ready = 1'b0;
    tick();
    rst = 1'b1;
    data_in_valid = 1'b1; data_in = 20'h12345;
    tick();
    data_in_valid = 1'b0; data_in = '0;
    read(16'h0555, 20'h0AAAA, 0, 0, 1'b0, got, n);
    chk("late_dv_miss", 64'(n), 64'(2));
    chk("late_dv_data", 64'(got), 64'h0AAAA);
    @(negedge clk); chk("late_dv_count", 64'(miss_count), 64'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule

`default_nettype wire
